// File: rtl/gerador_termometro.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gerador_termometro: turns a 0..8 count into a thermometer LED pattern,   |
// | one LED per DIVISOR cycles. Optional macro ESVAZIAR_EN: keep the current |
// | level on start and step up or down. Rev 1.0                              |
// +--------------------------------------------------------------------------+
module gerador_termometro #(
    parameter int DIVISOR = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] contagem,
    output logic [7:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] nivel
);

    localparam logic [15:0] PRESC_MAX = 16'(DIVISOR - 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        PREENCHE = 2'd1,
        CONCLUI  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [15:0] presc, presc_nx;
    logic [3:0]  alvo, alvo_nx;
    logic [7:0]  leds_nx;
    logic [3:0]  nivel_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= OCIOSO;
            presc   <= '0;
            alvo    <= '0;
            leds    <= '0;
            nivel   <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            state   <= state_nx;
            presc   <= presc_nx;
            alvo    <= alvo_nx;
            leds    <= leds_nx;
            nivel   <= nivel_nx;
            ocupado <= (state_nx != OCIOSO);
            pronto  <= (state_nx == CONCLUI);
        end
    end

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        alvo_nx  = alvo;
        leds_nx  = leds;
        nivel_nx = nivel;
        case (state)
            OCIOSO: begin
                if (start) begin
                    alvo_nx  = (contagem > 4'd8) ? 4'd8 : contagem;
                    presc_nx = '0;
`ifndef ESVAZIAR_EN
                    leds_nx  = '0;
                    nivel_nx = '0;
`endif
                    state_nx = PREENCHE;
                end
            end
            PREENCHE: begin
                presc_nx = (presc == PRESC_MAX) ? 16'd0 : presc + 16'd1;
                // Completion is checked before stepping so the last step is visible for one full cycle.
                if (nivel == alvo) begin
                    state_nx = CONCLUI;
                end else if (presc == PRESC_MAX) begin
                    if (nivel < alvo) begin
                        leds_nx  = {leds[6:0], 1'b1};
                        nivel_nx = nivel + 4'd1;
                    end
`ifdef ESVAZIAR_EN
                    else begin
                        leds_nx  = {1'b0, leds[7:1]};
                        nivel_nx = nivel - 4'd1;
                    end
`endif
                end
            end
            CONCLUI: state_nx = OCIOSO;
            default: state_nx = OCIOSO;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gerador_termometro.sv
`default_nettype none
// tb_gerador_termometro: two instances (DIVISOR 4 and 1) share stimulus and are compared
// every cycle against an arithmetic level-versus-time model, plus fixed vectors.
module tb_gerador_termometro;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic [3:0] contagem = 4'd0;
    logic [7:0] leds_a, leds_b;
    logic [3:0] nivel_a, nivel_b;
    logic       ocupado_a, ocupado_b, pronto_a, pronto_b;

    gerador_termometro #(.DIVISOR(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .contagem(contagem),
        .leds(leds_a), .ocupado(ocupado_a), .pronto(pronto_a), .nivel(nivel_a)
    );

    gerador_termometro #(.DIVISOR(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .contagem(contagem),
        .leds(leds_b), .ocupado(ocupado_b), .pronto(pronto_b), .nivel(nivel_b)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    // Model: a request accepted at edge t0 moves the level from n0 toward tgt by
    // floor((edge-t0)/D) steps (clamped); pronto lands at edge t0 + |tgt-n0|*D + 1.
    int div_m [2] = '{4, 1};
    int lvl   [2] = '{0, 0};
    int n0    [2] = '{0, 0};
    int tgt   [2] = '{0, 0};
    int t0    [2] = '{0, 0};
    int done  [2] = '{0, 0};
    bit act   [2] = '{1'b0, 1'b0};
    bit exp_ocup   [2];
    bit exp_pronto [2];

    typedef struct {
        logic [3:0] contagem;
        logic [7:0] leds;
        logic [3:0] nivel;
        int         done_a;
        int         done_b;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] fill5 [5];
    logic [7:0] seq32 [3];
    logic [7:0] first32;
    int         done32;
    logic [7:0] div1 [8];
    int         e0, pa, pb;

    function automatic int thermo(input int n);
        return (1 << n) - 1;
    endfunction

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, got, want, edge_n);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int t, steps, s;
            if ((!act[i] || (edge_n - t0[i] >= done[i] + 2)) && start) begin
`ifdef ESVAZIAR_EN
                n0[i] = lvl[i];
`else
                n0[i] = 0;
`endif
                tgt[i]  = (contagem > 4'd8) ? 8 : int'(contagem);
                steps   = (tgt[i] >= n0[i]) ? tgt[i] - n0[i] : n0[i] - tgt[i];
                done[i] = steps * div_m[i] + 1;
                t0[i]   = edge_n;
                act[i]  = 1'b1;
            end
            exp_ocup[i]   = 1'b0;
            exp_pronto[i] = 1'b0;
            if (act[i]) begin
                t     = edge_n - t0[i];
                steps = (tgt[i] >= n0[i]) ? tgt[i] - n0[i] : n0[i] - tgt[i];
                s     = t / div_m[i];
                if (s > steps) s = steps;
                lvl[i]        = (tgt[i] >= n0[i]) ? n0[i] + s : n0[i] - s;
                exp_ocup[i]   = (t <= done[i]);
                exp_pronto[i] = (t == done[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        model_edge();
        check("leds_a",    leds_a,    thermo(lvl[0]));
        check("nivel_a",   nivel_a,   lvl[0]);
        check("ocupado_a", ocupado_a, exp_ocup[0]);
        check("pronto_a",  pronto_a,  exp_pronto[0]);
        check("leds_b",    leds_b,    thermo(lvl[1]));
        check("nivel_b",   nivel_b,   lvl[1]);
        check("ocupado_b", ocupado_b, exp_ocup[1]);
        check("pronto_b",  pronto_b,  exp_pronto[1]);
    endtask

    // Called right after tick(): reset pulses between clock edges.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        start = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            lvl[i] = 0;
            act[i] = 1'b0;
        end
        check("rst_leds_a",    leds_a,    0);
        check("rst_nivel_a",   nivel_a,   0);
        check("rst_ocupado_a", ocupado_a, 0);
        check("rst_pronto_a",  pronto_a,  0);
        check("rst_leds_b",    leds_b,    0);
        check("rst_ocupado_b", ocupado_b, 0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'd0,  8'h00, 4'd0, 1,  1};
        tbl[1] = '{4'd1,  8'h01, 4'd1, 5,  2};
        tbl[2] = '{4'd3,  8'h07, 4'd3, 13, 4};
        tbl[3] = '{4'd5,  8'h1F, 4'd5, 21, 6};
        tbl[4] = '{4'd8,  8'hFF, 4'd8, 33, 9};
        tbl[5] = '{4'd9,  8'hFF, 4'd8, 33, 9};
        tbl[6] = '{4'd12, 8'hFF, 4'd8, 33, 9};
        tbl[7] = '{4'd15, 8'hFF, 4'd8, 33, 9};
        fill5  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
        div1   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
`ifdef ESVAZIAR_EN
        seq32   = '{8'h0F, 8'h07, 8'h03};
        first32 = 8'h1F;
        done32  = 13;
`else
        seq32   = '{8'h01, 8'h03, 8'h03};
        first32 = 8'h00;
        done32  = 9;
`endif

        #12;
        check("init_leds",    leds_a,    0);
        check("init_nivel",   nivel_a,   0);
        check("init_ocupado", ocupado_a, 0);
        check("init_pronto",  pronto_a,  0);
        reset = 1'b0;

        // Fill to 5 on the first edge after reset; a second start mid-fill is ignored.
        start = 1'b1; contagem = 4'd5;
        tick();
        e0 = edge_n;
        start = 1'b0;
        check("fill5_accept_ocupado", ocupado_a, 1);
        for (int k = 1; k <= 23; k++) begin
            if (k == 10) begin start = 1'b1; contagem = 4'd2; end
            if (k == 11) start = 1'b0;
            tick();
            if ((k % 4 == 0) && (k <= 20)) check("fill5_leds", leds_a, fill5[k/4 - 1]);
            check("fill5_pronto",  pronto_a,  k == 21);
            check("fill5_ocupado", ocupado_a, k <= 21);
        end
        check("fill5_final", leds_a, 8'h1F);

        // From leds=1F, request 2: drains with ESVAZIAR_EN, refills from zero otherwise.
        start = 1'b1; contagem = 4'd2;
        tick();
        start = 1'b0;
        check("req2_first", leds_a, first32);
        for (int k = 1; k <= 15; k++) begin
            tick();
            if ((k % 4 == 0) && (k <= 12)) check("req2_leds", leds_a, seq32[k/4 - 1]);
            check("req2_pronto", pronto_a, k == done32);
        end

        // Abort mid-fill at nivel=3: no pronto may follow.
        async_reset();
        start = 1'b1; contagem = 4'd8;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) tick();
        check("abort_nivel_before", nivel_a, 3);
        async_reset();
        for (int k = 0; k < 40; k++) begin
            tick();
            check("abort_no_pronto", pronto_a, 0);
        end

        // DIVISOR=1: one LED per cycle.
        start = 1'b1; contagem = 4'd8;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k <= 8) check("div1_leds", leds_b, div1[k-1]);
            check("div1_pronto", pronto_b, k == 9);
        end

        // Vector table: each entry from reset.
        for (int v = 0; v < 8; v++) begin
            async_reset();
            start = 1'b1; contagem = tbl[v].contagem;
            tick();
            e0 = edge_n;
            start = 1'b0;
            pa = -1; pb = -1;
            for (int k = 1; k <= 36; k++) begin
                tick();
                if (pronto_a) pa = k;
                if (pronto_b) pb = k;
            end
            check("tbl_pronto_edge_a", pa, tbl[v].done_a);
            check("tbl_pronto_edge_b", pb, tbl[v].done_b);
            check("tbl_leds_a",  leds_a,  tbl[v].leds);
            check("tbl_nivel_a", nivel_a, tbl[v].nivel);
            check("tbl_leds_b",  leds_b,  tbl[v].leds);
            check("tbl_nivel_b", nivel_b, tbl[v].nivel);
        end

        // Random traffic, including starts while busy and occasional resets.
        async_reset();
        for (int n = 0; n < 500; n++) begin
            start    = ($urandom_range(0, 3) == 0);
            contagem = 4'($urandom_range(0, 15));
            tick();
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
